// File: rtl/aw_w_round_robin_arbiter_pkg.sv
// axi_node_pkg: shared FSM type, idle-select code and round-robin search for the write-path arbiter
package axi_node_pkg;
  localparam int MAX_REQ = 7;
  // "none" select code of the standard 5-port node, also its default port count
  localparam int SEL_NONE = 5;
  typedef enum logic {ARB = 1'b0, GRANT = 1'b1} aw_state_t;
  // First set bit of req searching from (ptr+1) mod n upward with wrap; n when none set
  function automatic int rr_next(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
    logic [2:0] idx;
    rr_next = n;
    for (int i = MAX_REQ; i >= 1; i--) begin
      idx = 3'((ptr + i) % n);
      if (i <= n && req[idx])
        rr_next = int'(idx);
    end
  endfunction
endpackage

// File: rtl/aw_w_round_robin_arbiter_w_order_fifo.sv
// w_order_fifo: records granted AW port indices so W bursts follow AW order
module w_order_fifo #(
  parameter int W = 3,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0] count;
  logic wr;
  logic rd;
  assign rd = pop && !empty;
  assign wr = push && (!full || rd);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (wr)
        mem[wr_ptr] <= din;
      wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= rd ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/aw_w_round_robin_arbiter.sv
// aw_w_round_robin_arbiter: round-robin AW arbitration with W bursts steered in AW grant order
module aw_w_round_robin_arbiter
  import axi_node_pkg::*;
#(
  parameter int NUM_REQ = SEL_NONE,
  parameter int SEL_W = $clog2(NUM_REQ + 1),
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] AWVALID,
  output logic [NUM_REQ-1:0] AWREADY,
  output logic               M_AWVALID,
  input  logic               M_AWREADY,
  output logic [SEL_W-1:0]   AW_SLV_sel,
  input  logic [NUM_REQ-1:0] WVALID,
  input  logic [NUM_REQ-1:0] WLAST,
  output logic [NUM_REQ-1:0] WREADY,
  output logic               M_WVALID,
  input  logic               M_WREADY,
  output logic [SEL_W-1:0]   W_SLV_sel,
  output logic               fifo_full
);
  localparam logic [SEL_W-1:0] NONE = SEL_W'(NUM_REQ);
  aw_state_t state;
  logic [SEL_W-1:0] aw_sel;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] winner;
  logic [SEL_W-1:0] head;
  logic push;
  logic pop;
  logic empty;
  assign winner = SEL_W'(rr_next(MAX_REQ'(AWVALID), int'(rr_ptr), NUM_REQ));
  assign push = state == GRANT && M_AWREADY;
  assign M_AWVALID = state == GRANT;
  assign AW_SLV_sel = aw_sel;
  assign AWREADY = push ? NUM_REQ'(1) << aw_sel : '0;
  assign W_SLV_sel = empty ? NONE : head;
  assign M_WVALID = !empty && WVALID[head];
  assign WREADY = (!empty && M_WREADY) ? NUM_REQ'(1) << head : '0;
  assign pop = M_WVALID && M_WREADY && WLAST[head];
  // Full is only checked in ARB, so a grant already issued always completes
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ARB;
      aw_sel <= NONE;
      rr_ptr <= SEL_W'(NUM_REQ - 1);
    end else if (state == ARB) begin
      if (|AWVALID && !fifo_full) begin
        aw_sel <= winner;
        state <= GRANT;
      end
    end else if (M_AWREADY) begin
      aw_sel <= NONE;
      rr_ptr <= aw_sel;
      state <= ARB;
    end
  w_order_fifo #(
    .W(SEL_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .pop(pop),
    .din(aw_sel),
    .full(fifo_full),
    .empty(empty),
    .head(head)
  );
endmodule

// File: tb/tb_aw_w_round_robin_arbiter.sv
// tb_aw_w_round_robin_arbiter: directed vector table plus a push/pop-same-cycle sequence
module tb_aw_w_round_robin_arbiter;
  logic clk = 0;
  logic reset = 1;
  logic [4:0] awvalid = 0, awready, wvalid = 0, wlast = 0, wready;
  logic m_awvalid, m_awready = 0, m_wvalid, m_wready = 0, fifo_full;
  logic [2:0] aw_sel, w_sel;
  int checks = 0;
  int errors = 0;
  int n;

  typedef struct {
    logic rst; logic [4:0] awv; logic mawr; logic [4:0] wv; logic [4:0] wl; logic mwr;
    logic mawv; logic [2:0] aws; logic [4:0] awr; logic mwv; logic [2:0] ws; logic [4:0] wr; logic full;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  aw_w_round_robin_arbiter dut (
    .clk(clk), .reset(reset),
    .AWVALID(awvalid), .AWREADY(awready), .M_AWVALID(m_awvalid), .M_AWREADY(m_awready),
    .AW_SLV_sel(aw_sel), .WVALID(wvalid), .WLAST(wlast), .WREADY(wready),
    .M_WVALID(m_wvalid), .M_WREADY(m_wready), .W_SLV_sel(w_sel), .fifo_full(fifo_full)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [4:0] awv, input logic mawr, input logic [4:0] wv,
                     input logic [4:0] wl, input logic mwr, input logic mawv, input logic [2:0] aws,
                     input logic [4:0] awr, input logic mwv, input logic [2:0] ws, input logic [4:0] wr,
                     input logic full);
    tbl.push_back('{rst, awv, mawr, wv, wl, mwr, mawv, aws, awr, mwv, ws, wr, full});
  endtask

  initial begin
    // reset, then reset asserted while in GRANT
    add(1, 5'b00000, 0, 5'b00000, 5'b00000, 0,  0, 5, 5'b00000, 0, 5, 5'b00000, 0);
    add(0, 5'b00001, 0, 5'b00000, 5'b00000, 0,  0, 5, 5'b00000, 0, 5, 5'b00000, 0);
    add(0, 5'b00001, 0, 5'b00000, 5'b00000, 0,  1, 0, 5'b00000, 0, 5, 5'b00000, 0);
    add(1, 5'b00001, 1, 5'b00000, 5'b00000, 0,  0, 5, 5'b00000, 0, 5, 5'b00000, 0);
    // 10101 held: grants 0,2,4,0 then FIFO full, pop releases the 5th grant (2)
    add(0, 5'b10101, 1, 5'b00000, 5'b00000, 0,  0, 5, 5'b00000, 0, 5, 5'b00000, 0);
    add(0, 5'b10101, 1, 5'b00000, 5'b00000, 0,  1, 0, 5'b00001, 0, 5, 5'b00000, 0);
    add(0, 5'b10101, 1, 5'b00000, 5'b00000, 0,  0, 5, 5'b00000, 0, 0, 5'b00000, 0);
    add(0, 5'b10101, 1, 5'b00000, 5'b00000, 0,  1, 2, 5'b00100, 0, 0, 5'b00000, 0);
    add(0, 5'b10101, 1, 5'b00000, 5'b00000, 0,  0, 5, 5'b00000, 0, 0, 5'b00000, 0);
    add(0, 5'b10101, 1, 5'b00000, 5'b00000, 0,  1, 4, 5'b10000, 0, 0, 5'b00000, 0);
    add(0, 5'b10101, 1, 5'b00000, 5'b00000, 0,  0, 5, 5'b00000, 0, 0, 5'b00000, 0);
    add(0, 5'b10101, 1, 5'b00000, 5'b00000, 0,  1, 0, 5'b00001, 0, 0, 5'b00000, 0);
    add(0, 5'b10101, 1, 5'b00000, 5'b00000, 0,  0, 5, 5'b00000, 0, 0, 5'b00000, 1);
    add(0, 5'b10101, 1, 5'b00000, 5'b00000, 0,  0, 5, 5'b00000, 0, 0, 5'b00000, 1);
    add(0, 5'b10101, 1, 5'b00001, 5'b00001, 1,  0, 5, 5'b00000, 1, 0, 5'b00001, 1);
    add(0, 5'b10101, 1, 5'b00000, 5'b00000, 0,  0, 5, 5'b00000, 0, 2, 5'b00000, 0);
    add(0, 5'b10101, 1, 5'b00000, 5'b00000, 0,  1, 2, 5'b00100, 0, 2, 5'b00000, 0);
    add(1, 5'b00000, 0, 5'b00000, 5'b00000, 0,  0, 5, 5'b00000, 0, 5, 5'b00000, 0);
    // port 3 AW then a 4-beat burst; W presented early is stalled
    add(0, 5'b01000, 1, 5'b00000, 5'b00000, 0,  0, 5, 5'b00000, 0, 5, 5'b00000, 0);
    add(0, 5'b01000, 1, 5'b01000, 5'b00000, 1,  1, 3, 5'b01000, 0, 5, 5'b00000, 0);
    add(0, 5'b00000, 1, 5'b01000, 5'b00000, 1,  0, 5, 5'b00000, 1, 3, 5'b01000, 0);
    add(0, 5'b00000, 1, 5'b01000, 5'b00000, 1,  0, 5, 5'b00000, 1, 3, 5'b01000, 0);
    add(0, 5'b00000, 1, 5'b01000, 5'b00000, 1,  0, 5, 5'b00000, 1, 3, 5'b01000, 0);
    add(0, 5'b00000, 1, 5'b01000, 5'b01000, 1,  0, 5, 5'b00000, 1, 3, 5'b01000, 0);
    add(0, 5'b00000, 1, 5'b00000, 5'b00000, 1,  0, 5, 5'b00000, 0, 5, 5'b00000, 0);
    // AW 1 then 2; port 2 W waits until port 1 WLAST is taken
    add(0, 5'b00110, 1, 5'b00100, 5'b00100, 1,  0, 5, 5'b00000, 0, 5, 5'b00000, 0);
    add(0, 5'b00110, 1, 5'b00100, 5'b00100, 1,  1, 1, 5'b00010, 0, 5, 5'b00000, 0);
    add(0, 5'b00100, 1, 5'b00100, 5'b00100, 1,  0, 5, 5'b00000, 0, 1, 5'b00010, 0);
    add(0, 5'b00100, 1, 5'b00110, 5'b00100, 1,  1, 2, 5'b00100, 1, 1, 5'b00010, 0);
    add(0, 5'b00000, 1, 5'b00110, 5'b00110, 1,  0, 5, 5'b00000, 1, 1, 5'b00010, 0);
    add(0, 5'b00000, 1, 5'b00100, 5'b00100, 1,  0, 5, 5'b00000, 1, 2, 5'b00100, 0);
    add(0, 5'b00000, 0, 5'b00000, 5'b00000, 0,  0, 5, 5'b00000, 0, 5, 5'b00000, 0);
    // M_AWREADY low for 3 cycles in GRANT
    add(0, 5'b10000, 0, 5'b00000, 5'b00000, 0,  0, 5, 5'b00000, 0, 5, 5'b00000, 0);
    add(0, 5'b10000, 0, 5'b00000, 5'b00000, 0,  1, 4, 5'b00000, 0, 5, 5'b00000, 0);
    add(0, 5'b10000, 0, 5'b00000, 5'b00000, 0,  1, 4, 5'b00000, 0, 5, 5'b00000, 0);
    add(0, 5'b10000, 0, 5'b00000, 5'b00000, 0,  1, 4, 5'b00000, 0, 5, 5'b00000, 0);
    add(0, 5'b10000, 1, 5'b00000, 5'b00000, 0,  1, 4, 5'b10000, 0, 5, 5'b00000, 0);
    add(0, 5'b00000, 0, 5'b00000, 5'b00000, 0,  0, 5, 5'b00000, 0, 4, 5'b00000, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst;
      awvalid = tbl[i].awv;
      m_awready = tbl[i].mawr;
      wvalid = tbl[i].wv;
      wlast = tbl[i].wl;
      m_wready = tbl[i].mwr;
      #1;
      chk($sformatf("row%0d m_awvalid", i), m_awvalid, tbl[i].mawv);
      chk($sformatf("row%0d aw_sel", i), aw_sel, tbl[i].aws);
      chk($sformatf("row%0d awready", i), awready, tbl[i].awr);
      chk($sformatf("row%0d m_wvalid", i), m_wvalid, tbl[i].mwv);
      chk($sformatf("row%0d w_sel", i), w_sel, tbl[i].ws);
      chk($sformatf("row%0d wready", i), wready, tbl[i].wr);
      chk($sformatf("row%0d fifo_full", i), fifo_full, tbl[i].full);
    end

    // push of port 0 and pop of port 4 in the same cycle
    @(negedge clk);
    awvalid = 5'b00001;
    m_awready = 1;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!m_awvalid && n < 8);
    chk("h_awvalid_seen", m_awvalid, 1);
    chk("h_aw_sel", aw_sel, 0);
    wvalid = 5'b10000;
    wlast = 5'b10000;
    m_wready = 1;
    #1;
    chk("h_pop_mwvalid", m_wvalid, 1);
    chk("h_pop_wsel", w_sel, 4);
    @(negedge clk);
    awvalid = 0;
    m_awready = 0;
    wvalid = 0;
    wlast = 0;
    m_wready = 0;
    #1;
    chk("h_after_wsel", w_sel, 0);
    chk("h_after_full", fifo_full, 0);
    chk("h_after_awvalid", m_awvalid, 0);
    wvalid = 5'b00001;
    wlast = 5'b00001;
    m_wready = 1;
    @(negedge clk);
    wvalid = 0;
    wlast = 0;
    m_wready = 0;
    #1;
    chk("h_drained_wsel", w_sel, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
